piso_arb_ctrl: RTL and testbench

PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

---
 rtl/piso_arb_ctrl.sv | 141 ++++++++++++++
 tb/tb_piso_arb_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/piso_arb_ctrl.sv
// piso_arb_ctrl: two-requester round-robin arbiter feeding a MSB-first parallel-to-serial framer.
//   Parameter WIDTH (2..16): parallel word width.
//   Ports: clk, rst (sync, active-high);
//          req0_valid/req0_data/req0_ready, req1_valid/req1_data/req1_ready (valid/ready word inputs);
//          sout, sout_valid, sout_first, sout_last (serial frame output, registered);
//          gnt_id (source of current/last frame), busy (FSM not idle).
//   Macro PISO_PARITY_EN: appends an even-parity bit cycle after the data bits.
module piso_arb_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last,
    output logic             gnt_id,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             gnt_q, gnt_d;
    logic             sout_q, sout_d;
    logic             vld_q, vld_d;
    logic             first_q, first_d;
    logic             fin_q, fin_d;
    logic             busy_q, busy_d;
    logic             pick1, grant;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        // requester 1 wins when alone, or when both ask and requester 0 had the last grant
        pick1      = req1_valid && (!req0_valid || !last_q);
        grant      = !rst && state_q == IDLE && (req0_valid || req1_valid);
        req0_ready = grant && !pick1;
        req1_ready = grant && pick1;
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
`ifdef PISO_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant) begin
                    sr_d    = pick1 ? req1_data : req0_data;
                    cnt_d   = CW'(1);
                    gnt_d   = pick1;
                    last_d  = pick1;
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    par_d   = ^sr_d;
`endif
                end
            end
            SHIFT: begin
                // cnt_q counts bits already presented; it tops out at WIDTH and never wraps
                if (cnt_q == CW'(WIDTH)) begin
                    cnt_d   = '0;
`ifdef PISO_PARITY_EN
                    state_d = PAR;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    sr_d  = sr_q << 1;
                end
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next-state view so they line up with state_q
        vld_d   = state_d != IDLE;
        busy_d  = state_d != IDLE;
        first_d = state_q == IDLE && state_d == SHIFT;
`ifdef PISO_PARITY_EN
        sout_d  = state_d == PAR ? par_q : (state_d == SHIFT && sr_d[WIDTH-1]);
        fin_d   = state_d == PAR;
`else
        sout_d  = state_d == SHIFT && sr_d[WIDTH-1];
        fin_d   = state_d == SHIFT && cnt_d == CW'(WIDTH);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            sout_q  <= 1'b0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            sout_q  <= sout_d;
            vld_q   <= vld_d;
            first_q <= first_d;
            fin_q   <= fin_d;
            busy_q  <= busy_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign sout       = sout_q;
    assign sout_valid = vld_q;
    assign sout_first = first_q;
    assign sout_last  = fin_q;
    assign gnt_id     = gnt_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_piso_arb_ctrl.sv
// tb_piso_arb_ctrl: self-checking bench for piso_arb_ctrl (WIDTH=4).
//   A cycle model predicts ready/busy/gnt_id; granted words are expanded into expected
//   serial bits on a scoreboard queue and popped as the DUT emits frame bits.
//   Honors PISO_PARITY_EN the same way as the design.
module tb_piso_arb_ctrl;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int P = W + PB + 1;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
        logic g;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v0 = 1'b0, v1 = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0;
    logic         r0, r1, sout, sout_valid, sout_first, sout_last, gnt_id, busy;

    exp_t sb[$];
    exp_t x;
    int   n_vec = 0, n_err = 0;
    bit   mon_en = 1'b0;
    int   m_rem = 0;
    logic m_last = 1'b1, m_gnt = 1'b0, e0, e1;

    piso_arb_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
        .sout(sout), .sout_valid(sout_valid), .sout_first(sout_first), .sout_last(sout_last),
        .gnt_id(gnt_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [W-1:0] d, input logic g);
        for (int i = W - 1; i >= 0; i--)
            sb.push_back('{b: d[i], f: (i == W - 1), l: (PB == 0 && i == 0), g: g});
        if (PB == 1)
            sb.push_back('{b: ^d, f: 1'b0, l: 1'b1, g: g});
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            e0 = !rst && m_rem == 0 && v0 && (!v1 || m_last);
            e1 = !rst && m_rem == 0 && v1 && (!v0 || !m_last);
            chk("busy", busy, m_rem != 0);
            chk("ready0", r0, e0);
            chk("ready1", r1, e1);
            chk("gnt_id", gnt_id, m_gnt);
            if (m_rem == 0)
                chk("idle_out", {sout, sout_valid, sout_first, sout_last}, 0);
            if (sout_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    x = sb.pop_front();
                    chk("sout", sout, x.b);
                    chk("sout_first", sout_first, x.f);
                    chk("sout_last", sout_last, x.l);
                    chk("frame_gnt", gnt_id, x.g);
                end
            end
            if (rst) begin
                m_rem = 0;
                m_last = 1'b1;
                m_gnt = 1'b0;
                sb.delete();
            end else if (m_rem > 0) begin
                m_rem--;
            end else if (e0 || e1) begin
                push_frame(e1 ? d1 : d0, e1);
                m_rem = W + PB;
                m_last = e1;
                m_gnt = e1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input bit which);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(which ? r1 : r0) && n < 50);
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with req0 already valid: ready must stay low until reset drops
        d0 = 4'b1010;
        v0 = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(1);
        rst = 1'b0;
        wait_acc(0);
        v0 = 1'b0;
        cyc(P + 1);
        // contention from a fresh reset: 0,1,0,1
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        d0 = 4'b1101;
        d1 = 4'b0011;
        v0 = 1'b1;
        v1 = 1'b1;
        cyc(4 * P);
        v0 = 1'b0;
        v1 = 1'b0;
        cyc(P + 1);
        // lone requester 1 for three back-to-back frames
        d1 = 4'b0101;
        v1 = 1'b1;
        cyc(3 * P);
        v1 = 1'b0;
        cyc(P + 1);
        // reset after the 2nd bit of 1111, then a clean frame
        d0 = 4'b1111;
        v0 = 1'b1;
        wait_acc(0);
        v0 = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        d0 = 4'b0110;
        v0 = 1'b1;
        wait_acc(0);
        v0 = 1'b0;
        cyc(P + 1);
        // data changes after acceptance must not leak into the frame
        d0 = 4'b1001;
        v0 = 1'b1;
        wait_acc(0);
        v0 = 1'b0;
        d0 = 4'b0000;
        cyc(P + 1);
        // idle stretch
        cyc(20);
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
